// File: rtl/mem_port_arbiter_pkg.sv
// High-level control types for the unified memory port arbiter:
// FSM state and owner encodings, bus widths and small helpers.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package mem_port_arbiter_pkg;

    localparam int WordSize    = `WORD_SIZE;
    localparam int ByteEnWidth = WordSize / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } memArbState;

    typedef enum logic {
        OWNER_DATA  = 1'b0,
        OWNER_FETCH = 1'b1
    } memOwner;

    // A granted fetch must be discarded when a redirect is present now
    // or was latched while the request was waiting for its grant.
    function automatic logic fetchDiscard(input memOwner owner,
                                          input logic flushNow,
                                          input logic flushSeen);
        logic discard;
        if (owner == OWNER_FETCH) begin
            discard = flushNow | flushSeen;
        end else begin
            discard = 1'b0;
        end
        return discard;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Unified memory port: req/gnt/rvalid handshake between the arbiter
// (master) and the memory (slave).
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
();

    logic                   MemReq;
    logic                   MemWriteEn;
    logic [WordSize-1:0]    MemAdr;
    logic [WordSize-1:0]    MemWriteData;
    logic [ByteEnWidth-1:0] MemByteEn;
    logic                   MemGnt;
    logic                   MemRValid;
    logic [WordSize-1:0]    MemRData;

    modport master (
        output MemReq,
        output MemWriteEn,
        output MemAdr,
        output MemWriteData,
        output MemByteEn,
        input  MemGnt,
        input  MemRValid,
        input  MemRData
    );

    modport slave (
        input  MemReq,
        input  MemWriteEn,
        input  MemAdr,
        input  MemWriteData,
        input  MemByteEn,
        output MemGnt,
        output MemRValid,
        output MemRData
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's single memory port between instruction fetch
// and load/store. Data has strict priority; a fetch redirected while
// outstanding has its response swallowed in DROP. Request fields are
// registered on selection and held until the memory grants them.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   IFetchReq,
    input  logic [WordSize-1:0]    IFetchAdr,
    input  logic                   FetchFlush,
    output logic                   IFetchValid,
    output logic [31:0]            IFetchData,

    input  logic                   DataReq,
    input  logic                   DataWriteEn,
    input  logic [WordSize-1:0]    DataAdr,
    input  logic [WordSize-1:0]    DataWriteData,
    input  logic [ByteEnWidth-1:0] DataByteEn,
    output logic                   DataValid,
    output logic [WordSize-1:0]    DataReadData,

    mem_port_arbiter_if.master     memBus,

    output logic                   StallFetch,
    output logic                   StallData,
    output logic                   ProtocolError
);

    memArbState             stateR;
    memOwner                ownerR;
    logic                   flushSeenR;
    logic                   memReqR;
    logic                   memWriteEnR;
    logic [WordSize-1:0]    memAdrR;
    logic [WordSize-1:0]    memWriteDataR;
    logic [ByteEnWidth-1:0] memByteEnR;
    logic                   protocolErrorR;

    logic                   iFetchValidS;
    logic                   dataValidS;

    // Arbitration FSM with the registered memory request fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateR         <= IDLE;
            ownerR         <= OWNER_DATA;
            flushSeenR     <= 1'b0;
            memReqR        <= 1'b0;
            memWriteEnR    <= 1'b0;
            memAdrR        <= '0;
            memWriteDataR  <= '0;
            memByteEnR     <= '0;
            protocolErrorR <= 1'b0;
        end else begin
            // A response with nothing outstanding is a memory-side fault.
            if (memBus.MemRValid && (stateR == IDLE || stateR == REQ)) begin
                protocolErrorR <= 1'b1;
            end else begin
                protocolErrorR <= protocolErrorR;
            end

            case (stateR)
                IDLE: begin
                    flushSeenR <= 1'b0;
                    if (DataReq) begin
                        ownerR        <= OWNER_DATA;
                        memReqR       <= 1'b1;
                        memWriteEnR   <= DataWriteEn;
                        memAdrR       <= DataAdr;
                        memWriteDataR <= DataWriteData;
                        memByteEnR    <= DataByteEn;
                        stateR        <= REQ;
                    end else if (IFetchReq && !FetchFlush) begin
                        ownerR        <= OWNER_FETCH;
                        memReqR       <= 1'b1;
                        memWriteEnR   <= 1'b0;
                        memAdrR       <= IFetchAdr;
                        memWriteDataR <= '0;
                        memByteEnR    <= '1;
                        stateR        <= REQ;
                    end else begin
                        stateR <= IDLE;
                    end
                end

                REQ: begin
                    // Remember a redirect so the late grant is still dropped.
                    if (FetchFlush && ownerR == OWNER_FETCH) begin
                        flushSeenR <= 1'b1;
                    end else begin
                        flushSeenR <= flushSeenR;
                    end
                    if (memBus.MemGnt) begin
                        memReqR <= 1'b0;
                        if (fetchDiscard(ownerR, FetchFlush, flushSeenR)) begin
                            stateR <= DROP;
                        end else begin
                            stateR <= WAIT;
                        end
                    end else begin
                        stateR <= REQ;
                    end
                end

                WAIT: begin
                    if (memBus.MemRValid) begin
                        stateR <= IDLE;
                    end else if (FetchFlush && ownerR == OWNER_FETCH) begin
                        stateR <= DROP;
                    end else begin
                        stateR <= WAIT;
                    end
                end

                DROP: begin
                    if (memBus.MemRValid) begin
                        stateR <= IDLE;
                    end else begin
                        stateR <= DROP;
                    end
                end

                default: begin
                    stateR  <= IDLE;
                    memReqR <= 1'b0;
                end
            endcase
        end
    end

    // Route the response to its owner in the cycle it arrives; a fetch
    // response coinciding with a redirect is suppressed.
    always_comb begin
        iFetchValidS = 1'b0;
        dataValidS   = 1'b0;
        if (!reset && stateR == WAIT && memBus.MemRValid) begin
            if (ownerR == OWNER_DATA) begin
                dataValidS = 1'b1;
            end else begin
                iFetchValidS = ~FetchFlush;
            end
        end else begin
            iFetchValidS = 1'b0;
            dataValidS   = 1'b0;
        end
    end

    assign IFetchValid  = iFetchValidS;
    assign DataValid    = dataValidS;
    assign IFetchData   = memBus.MemRData[31:0];
    assign DataReadData = memBus.MemRData;

    assign StallData  = DataReq & ~dataValidS;
    assign StallFetch = (IFetchReq & ~iFetchValidS & ~FetchFlush) | StallData;

    assign ProtocolError = protocolErrorR;

    assign memBus.MemReq       = memReqR;
    assign memBus.MemWriteEn   = memWriteEnR;
    assign memBus.MemAdr       = memAdrR;
    assign memBus.MemWriteData = memWriteDataR;
    assign memBus.MemByteEn    = memByteEnR;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. The bench plays both the core
// and the memory; inputs change 1 time unit after the rising edge and
// outputs are compared 2 units later.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic                   clk;
    logic                   reset;
    logic                   IFetchReq;
    logic [WordSize-1:0]    IFetchAdr;
    logic                   FetchFlush;
    logic                   IFetchValid;
    logic [31:0]            IFetchData;
    logic                   DataReq;
    logic                   DataWriteEn;
    logic [WordSize-1:0]    DataAdr;
    logic [WordSize-1:0]    DataWriteData;
    logic [ByteEnWidth-1:0] DataByteEn;
    logic                   DataValid;
    logic [WordSize-1:0]    DataReadData;
    logic                   StallFetch;
    logic                   StallData;
    logic                   ProtocolError;

    int testsRun    = 0;
    int testsFailed = 0;

    mem_port_arbiter_if memBus ();

    mem_port_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .IFetchReq     (IFetchReq),
        .IFetchAdr     (IFetchAdr),
        .FetchFlush    (FetchFlush),
        .IFetchValid   (IFetchValid),
        .IFetchData    (IFetchData),
        .DataReq       (DataReq),
        .DataWriteEn   (DataWriteEn),
        .DataAdr       (DataAdr),
        .DataWriteData (DataWriteData),
        .DataByteEn    (DataByteEn),
        .DataValid     (DataValid),
        .DataReadData  (DataReadData),
        .memBus        (memBus),
        .StallFetch    (StallFetch),
        .StallData     (StallData),
        .ProtocolError (ProtocolError)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkEq(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clearInputs();
        IFetchReq        = 1'b0;
        IFetchAdr        = 32'h0;
        FetchFlush       = 1'b0;
        DataReq          = 1'b0;
        DataWriteEn      = 1'b0;
        DataAdr          = 32'h0;
        DataWriteData    = 32'h0;
        DataByteEn       = 4'h0;
        memBus.MemGnt    = 1'b0;
        memBus.MemRValid = 1'b0;
        memBus.MemRData  = 32'h0;
    endtask

    initial begin
        clearInputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        settle();
        checkEq("rst_memreq",  {31'd0, memBus.MemReq},     32'd0);
        checkEq("rst_memwe",   {31'd0, memBus.MemWriteEn}, 32'd0);
        checkEq("rst_memadr",  memBus.MemAdr,              32'd0);
        checkEq("rst_memwd",   memBus.MemWriteData,        32'd0);
        checkEq("rst_membe",   {28'd0, memBus.MemByteEn},  32'd0);
        checkEq("rst_ivalid",  {31'd0, IFetchValid},       32'd0);
        checkEq("rst_dvalid",  {31'd0, DataValid},         32'd0);
        checkEq("rst_perr",    {31'd0, ProtocolError},     32'd0);

        // Load: gnt in first REQ cycle, rvalid one cycle later.
        tick();
        DataReq = 1'b1; DataWriteEn = 1'b0; DataAdr = 32'h40; DataByteEn = 4'hF;
        settle();
        checkEq("ld_c0_stall",  {31'd0, StallData},     32'd1);
        checkEq("ld_c0_memreq", {31'd0, memBus.MemReq}, 32'd0);
        tick();
        memBus.MemGnt = 1'b1;
        settle();
        checkEq("ld_c1_memreq", {31'd0, memBus.MemReq}, 32'd1);
        checkEq("ld_c1_adr",    memBus.MemAdr,          32'h40);
        checkEq("ld_c1_stall",  {31'd0, StallData},     32'd1);
        tick();
        memBus.MemGnt = 1'b0; memBus.MemRValid = 1'b1; memBus.MemRData = 32'hDEADBEEF;
        settle();
        checkEq("ld_c2_dvalid", {31'd0, DataValid},     32'd1);
        checkEq("ld_c2_rdata",  DataReadData,           32'hDEADBEEF);
        checkEq("ld_c2_stall",  {31'd0, StallData},     32'd0);
        checkEq("ld_c2_memreq", {31'd0, memBus.MemReq}, 32'd0);
        tick();
        clearInputs();
        settle();
        checkEq("ld_c3_dvalid", {31'd0, DataValid},     32'd0);

        // Simultaneous data and fetch: data first, fetch right after.
        DataReq = 1'b1; DataAdr = 32'h200; DataByteEn = 4'hF;
        IFetchReq = 1'b1; IFetchAdr = 32'h1000;
        settle();
        checkEq("both_c0_sf", {31'd0, StallFetch}, 32'd1);
        tick();
        memBus.MemGnt = 1'b1;
        settle();
        checkEq("both_c1_adr", memBus.MemAdr,       32'h200);
        checkEq("both_c1_sf",  {31'd0, StallFetch}, 32'd1);
        tick();
        memBus.MemGnt = 1'b0; memBus.MemRValid = 1'b1; memBus.MemRData = 32'hCAFEF00D;
        settle();
        checkEq("both_c2_dvalid", {31'd0, DataValid},   32'd1);
        checkEq("both_c2_ivalid", {31'd0, IFetchValid}, 32'd0);
        checkEq("both_c2_sf",     {31'd0, StallFetch},  32'd1);
        tick();
        DataReq = 1'b0; memBus.MemRValid = 1'b0;
        settle();
        checkEq("both_c3_memreq", {31'd0, memBus.MemReq}, 32'd0);
        checkEq("both_c3_sf",     {31'd0, StallFetch},    32'd1);
        tick();
        memBus.MemGnt = 1'b1;
        settle();
        checkEq("both_c4_memreq", {31'd0, memBus.MemReq},     32'd1);
        checkEq("both_c4_adr",    memBus.MemAdr,              32'h1000);
        checkEq("both_c4_we",     {31'd0, memBus.MemWriteEn}, 32'd0);
        checkEq("both_c4_be",     {28'd0, memBus.MemByteEn},  32'hF);
        checkEq("both_c4_sf",     {31'd0, StallFetch},        32'd1);
        tick();
        memBus.MemGnt = 1'b0; memBus.MemRValid = 1'b1; memBus.MemRData = 32'h00A00093;
        settle();
        checkEq("both_c5_ivalid", {31'd0, IFetchValid}, 32'd1);
        checkEq("both_c5_idata",  IFetchData,           32'h00A00093);
        checkEq("both_c5_sf",     {31'd0, StallFetch},  32'd0);
        tick();
        clearInputs();

        // Store with grant held off for three REQ cycles.
        DataReq = 1'b1; DataWriteEn = 1'b1; DataAdr = 32'h100;
        DataWriteData = 32'h12345678; DataByteEn = 4'h3;
        tick();
        DataAdr = 32'hFFF0; DataWriteData = 32'h0; DataByteEn = 4'hF;
        for (int k = 0; k < 4; k++) begin
            settle();
            checkEq("st_memreq", {31'd0, memBus.MemReq},     32'd1);
            checkEq("st_we",     {31'd0, memBus.MemWriteEn}, 32'd1);
            checkEq("st_adr",    memBus.MemAdr,              32'h100);
            checkEq("st_wd",     memBus.MemWriteData,        32'h12345678);
            checkEq("st_be",     {28'd0, memBus.MemByteEn},  32'h3);
            if (k == 3) begin
                memBus.MemGnt = 1'b1;
            end
            tick();
        end
        memBus.MemGnt = 1'b0; memBus.MemRValid = 1'b1;
        settle();
        checkEq("st_ack",       {31'd0, DataValid},     32'd1);
        checkEq("st_ack_memreq", {31'd0, memBus.MemReq}, 32'd0);
        tick();
        clearInputs();

        // Redirect while a fetch waits for its response.
        IFetchReq = 1'b1; IFetchAdr = 32'h2000;
        tick();
        memBus.MemGnt = 1'b1;
        settle();
        checkEq("fw_c1_adr", memBus.MemAdr, 32'h2000);
        tick();
        memBus.MemGnt = 1'b0; FetchFlush = 1'b1;
        settle();
        checkEq("fw_c2_sf", {31'd0, StallFetch}, 32'd0);
        tick();
        FetchFlush = 1'b0; IFetchAdr = 32'h3000;
        memBus.MemRValid = 1'b1; memBus.MemRData = 32'h00000BAD;
        settle();
        checkEq("fw_drop_ivalid", {31'd0, IFetchValid},   32'd0);
        checkEq("fw_drop_perr",   {31'd0, ProtocolError}, 32'd0);
        checkEq("fw_drop_sf",     {31'd0, StallFetch},    32'd1);
        tick();
        memBus.MemRValid = 1'b0;
        settle();
        checkEq("fw_idle_memreq", {31'd0, memBus.MemReq}, 32'd0);
        tick();
        memBus.MemGnt = 1'b1;
        settle();
        checkEq("fw_new_memreq", {31'd0, memBus.MemReq}, 32'd1);
        checkEq("fw_new_adr",    memBus.MemAdr,          32'h3000);
        tick();
        memBus.MemGnt = 1'b0; memBus.MemRValid = 1'b1; memBus.MemRData = 32'h11112222;
        settle();
        checkEq("fw_new_ivalid", {31'd0, IFetchValid}, 32'd1);
        checkEq("fw_new_idata",  IFetchData,           32'h11112222);
        tick();
        clearInputs();

        // Redirect while the fetch is still waiting for its grant.
        IFetchReq = 1'b1; IFetchAdr = 32'h4000;
        tick();
        FetchFlush = 1'b1; IFetchReq = 1'b0;
        settle();
        checkEq("fr_c1_memreq", {31'd0, memBus.MemReq}, 32'd1);
        tick();
        FetchFlush = 1'b0; memBus.MemGnt = 1'b1;
        settle();
        checkEq("fr_c2_memreq", {31'd0, memBus.MemReq}, 32'd1);
        tick();
        memBus.MemGnt = 1'b0; memBus.MemRValid = 1'b1; memBus.MemRData = 32'h55AA55AA;
        settle();
        checkEq("fr_drop_ivalid", {31'd0, IFetchValid},   32'd0);
        checkEq("fr_drop_perr",   {31'd0, ProtocolError}, 32'd0);
        tick();
        clearInputs();

        // Redirect in IDLE with only a fetch pending: nothing issued.
        IFetchReq = 1'b1; IFetchAdr = 32'h5000; FetchFlush = 1'b1;
        settle();
        checkEq("fi_c0_sf", {31'd0, StallFetch}, 32'd0);
        tick();
        clearInputs();
        settle();
        checkEq("fi_c1_memreq", {31'd0, memBus.MemReq}, 32'd0);
        tick();

        // Reset in WAIT abandons the load.
        DataReq = 1'b1; DataAdr = 32'h300; DataByteEn = 4'hF;
        tick();
        memBus.MemGnt = 1'b1;
        tick();
        memBus.MemGnt = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        checkEq("rw_memreq", {31'd0, memBus.MemReq}, 32'd0);
        checkEq("rw_dvalid", {31'd0, DataValid},     32'd0);
        checkEq("rw_ivalid", {31'd0, IFetchValid},   32'd0);
        tick();
        memBus.MemGnt = 1'b1;
        settle();
        checkEq("rw_reissue", {31'd0, memBus.MemReq}, 32'd1);
        tick();
        memBus.MemGnt = 1'b0; memBus.MemRValid = 1'b1; memBus.MemRData = 32'h0000CAFE;
        settle();
        checkEq("rw_dvalid2", {31'd0, DataValid}, 32'd1);
        tick();
        clearInputs();
        settle();
        checkEq("pe_before", {31'd0, ProtocolError}, 32'd0);

        // Unsolicited response in IDLE sets the sticky error.
        memBus.MemRValid = 1'b1;
        tick();
        memBus.MemRValid = 1'b0;
        settle();
        checkEq("pe_set", {31'd0, ProtocolError}, 32'd1);
        tick();
        tick();
        settle();
        checkEq("pe_hold", {31'd0, ProtocolError}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        checkEq("pe_clear", {31'd0, ProtocolError}, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
